// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display controller: FSM state
// encoding, special segment patterns and the active-low BCD font (gfedcba).
package seg_pkg;

    typedef enum logic {
        SHOW_SCORE = 1'b0,
        SHOW_MSG   = 1'b1
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Digits 0..9 use the standard font; codes 10..15 are not BCD and show a dash.
    localparam logic [6:0] BCD_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
        SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
    };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational 4-bit to active-low seven-segment decoder with a blank override.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank wins over the font lookup.
    always_comb begin
        seg = blank ? SEG_BLANK : BCD_FONT[digit];
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Four-digit seven-segment display controller: free-running scan prescaler,
// score decode with optional leading-zero blanking, and a message takeover
// path that owns the display for MSG_HOLD scan ticks, optionally blinking.
//
// Handshake: a message transfers on a rising clk edge where msg_valid and
// msg_ready are both high; msg_seg/msg_blink are captured only on that edge,
// and msg_valid is ignored while msg_ready is low.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int MSG_HOLD    = 2000,
    parameter int BLINK_TICKS = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] score_bcd,
    input  logic        score_blank_lz,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [27:0] msg_seg,
    input  logic        msg_blink,
    output logic        msg_active,
    output logic        scan_tick,
    output logic [6:0]  first_cathode,
    output logic [6:0]  second_cathode,
    output logic [6:0]  third_cathode,
    output logic [6:0]  fourth_cathode
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HW = $clog2(MSG_HOLD + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);

    localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(MSG_HOLD);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    disp_state_t   state;
    disp_state_t   next_state;
    logic [PW-1:0] pre_cnt;
    logic [HW-1:0] hold_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic          blink_lat;
    logic [27:0]   msg_lat;
    logic          xfer;
    logic [3:0]    lz_blank;
    logic [6:0]    score_seg [4];

    assign xfer = msg_valid && msg_ready;

    // Free-running prescaler; scan_tick is high the cycle after the last count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt   <= '0;
            scan_tick <= 1'b0;
        end else begin
            pre_cnt   <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
            scan_tick <= (pre_cnt == PRE_LAST);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SHOW_SCORE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state: accept a message, release on the expiring scan tick.
    always_comb begin
        next_state = state;
        case (state)
            SHOW_SCORE: if (xfer) next_state = SHOW_MSG;
            SHOW_MSG:   if (scan_tick && hold_cnt == HOLD_LAST) next_state = SHOW_SCORE;
            default:    next_state = SHOW_SCORE;
        endcase
    end

    // FSM outputs, registered from the next state so they track the transition edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_ready  <= 1'b0;
            msg_active <= 1'b0;
        end else begin
            msg_ready  <= (next_state == SHOW_SCORE);
            msg_active <= (next_state == SHOW_MSG);
        end
    end

    // Message capture plus hold and blink counters, advanced by scan ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_lat     <= '0;
            blink_lat   <= 1'b0;
            hold_cnt    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (xfer) begin
            msg_lat     <= msg_seg;
            blink_lat   <= msg_blink;
            hold_cnt    <= HOLD_LOAD;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (state == SHOW_MSG && scan_tick) begin
            hold_cnt <= hold_cnt - 1'b1;
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Leading-zero blanking: a digit blanks when it and everything to its left are zero.
    always_comb begin
        lz_blank[0] = score_blank_lz && (score_bcd[15:12] == 4'h0);
        lz_blank[1] = score_blank_lz && (score_bcd[15:8] == 8'h00);
        lz_blank[2] = score_blank_lz && (score_bcd[15:4] == 12'h000);
        lz_blank[3] = 1'b0;
    end

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_to_seg u_dec (
            .digit (score_bcd[15-4*i -: 4]),
            .blank (lz_blank[i]),
            .seg   (score_seg[i])
        );
    end

    // Registered cathode mux: message (possibly blanked by blink) or decoded score.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_cathode  <= SEG_BLANK;
            second_cathode <= SEG_BLANK;
            third_cathode  <= SEG_BLANK;
            fourth_cathode <= SEG_BLANK;
        end else if (state == SHOW_MSG) begin
            if (blink_lat && !blink_phase) begin
                first_cathode  <= SEG_BLANK;
                second_cathode <= SEG_BLANK;
                third_cathode  <= SEG_BLANK;
                fourth_cathode <= SEG_BLANK;
            end else begin
                first_cathode  <= msg_lat[27:21];
                second_cathode <= msg_lat[20:14];
                third_cathode  <= msg_lat[13:7];
                fourth_cathode <= msg_lat[6:0];
            end
        end else begin
            first_cathode  <= score_seg[0];
            second_cathode <= score_seg[1];
            third_cathode  <= score_seg[2];
            fourth_cathode <= score_seg[3];
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl with a cycle-level reference model
// that counts edges and scan ticks arithmetically.
module tb_seg_display_ctrl;

    localparam int DIV  = 4;
    localparam int HOLD = 3;
    localparam int BT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] score_bcd;
    logic        score_blank_lz;
    logic        msg_valid;
    logic        msg_ready;
    logic [27:0] msg_seg;
    logic        msg_blink;
    logic        msg_active;
    logic        scan_tick;
    logic [6:0]  first_cathode, second_cathode, third_cathode, fourth_cathode;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    bit          m_msg;
    bit          m_ready;
    bit          m_tick;
    int          m_ticks;
    int          m_edges;
    logic [27:0] m_lat_seg;
    bit          m_lat_blink;
    logic [27:0] exp_q[$];

    seg_display_ctrl #(
        .REFRESH_DIV (DIV),
        .MSG_HOLD    (HOLD),
        .BLINK_TICKS (BT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .score_bcd      (score_bcd),
        .score_blank_lz (score_blank_lz),
        .msg_valid      (msg_valid),
        .msg_ready      (msg_ready),
        .msg_seg        (msg_seg),
        .msg_blink      (msg_blink),
        .msg_active     (msg_active),
        .scan_tick      (scan_tick),
        .first_cathode  (first_cathode),
        .second_cathode (second_cathode),
        .third_cathode  (third_cathode),
        .fourth_cathode (fourth_cathode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'd0: font = 7'h40;
            4'd1: font = 7'h79;
            4'd2: font = 7'h24;
            4'd3: font = 7'h30;
            4'd4: font = 7'h19;
            4'd5: font = 7'h12;
            4'd6: font = 7'h02;
            4'd7: font = 7'h78;
            4'd8: font = 7'h00;
            4'd9: font = 7'h10;
            default: font = 7'h3F;
        endcase
    endfunction

    function automatic logic [27:0] score_view(input logic [15:0] s, input logic lz);
        logic [27:0] v;
        logic [3:0]  d;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            d = 4'((s >> (12 - 4 * i)) & 16'hF);
            if (lz && i < 3 && (s >> (12 - 4 * i)) == 0) v[27-7*i -: 7] = 7'h7F;
            else v[27-7*i -: 7] = font(d);
        end
        return v;
    endfunction

    task automatic model_reset();
        m_msg = 0; m_ready = 0; m_tick = 0; m_ticks = 0; m_edges = 0;
        m_lat_seg = '0; m_lat_blink = 0;
    endtask

    // Advance the model by one rising edge using the inputs present before it.
    task automatic model_edge();
        logic [27:0] disp;
        if (m_msg) begin
            if (m_lat_blink && ((m_ticks / BT) % 2 == 1)) disp = {4{7'h7F}};
            else disp = m_lat_seg;
        end else begin
            disp = score_view(score_bcd, score_blank_lz);
        end
        exp_q.push_back(disp);
        if (!m_msg && m_ready && msg_valid) begin
            m_msg = 1; m_ticks = 0; m_lat_seg = msg_seg; m_lat_blink = msg_blink;
        end else if (m_msg && m_tick) begin
            m_ticks++;
            if (m_ticks == HOLD) m_msg = 0;
        end
        m_ready = !m_msg;
        m_edges++;
        m_tick = (m_edges % DIV == 0);
    endtask

    task automatic compare();
        logic [27:0] e;
        e = exp_q.pop_front();
        check("cath1", first_cathode,  e[27:21]);
        check("cath2", second_cathode, e[20:14]);
        check("cath3", third_cathode,  e[13:7]);
        check("cath4", fourth_cathode, e[6:0]);
        check("scan_tick", scan_tick, m_tick);
        check("msg_ready", msg_ready, m_ready);
        check("msg_active", msg_active, m_msg);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_blank_reset(input string tag);
        check({tag, "_c1"}, first_cathode, 7'h7F);
        check({tag, "_c2"}, second_cathode, 7'h7F);
        check({tag, "_c3"}, third_cathode, 7'h7F);
        check({tag, "_c4"}, fourth_cathode, 7'h7F);
        check({tag, "_tick"}, scan_tick, 1'b0);
        check({tag, "_ready"}, msg_ready, 1'b0);
        check({tag, "_active"}, msg_active, 1'b0);
    endtask

    function automatic logic [15:0] rand_score();
        logic [15:0] s;
        for (int i = 0; i < 4; i++)
            s[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 11));
        return s;
    endfunction

    task automatic send_msg(input logic [27:0] seg, input logic blink);
        msg_seg = seg; msg_blink = blink; msg_valid = 1'b1;
        step();
        msg_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; score_bcd = 16'h0107; score_blank_lz = 1'b1;
        msg_valid = 1'b0; msg_seg = '0; msg_blink = 1'b0;
        model_reset();
        #12;
        check_blank_reset("rst");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // prescaler and directed score patterns
        run(10);
        score_blank_lz = 1'b0;            run(10);
        score_bcd = 16'hA000;             run(10);
        score_bcd = 16'h0000; score_blank_lz = 1'b1; run(10);

        // plain message, score and message data churn underneath
        send_msg({7'h08, 7'h06, 7'h47, 7'h47}, 1'b0);
        for (int i = 0; i < 20; i++) begin
            score_bcd = rand_score();
            msg_seg = 28'($urandom);
            step();
        end

        // msg_valid held through a message: next one only after release
        msg_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            msg_seg = 28'($urandom);
            msg_blink = 1'($urandom_range(0, 1));
            step();
        end
        msg_valid = 1'b0;
        run(20);

        // blinking message
        send_msg({7'h12, 7'h24, 7'h30, 7'h19}, 1'b1);
        run(20);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            score_bcd = rand_score();
            score_blank_lz = 1'($urandom_range(0, 1));
            msg_valid = ($urandom_range(0, 7) == 0);
            msg_seg = 28'($urandom);
            msg_blink = 1'($urandom_range(0, 1));
            step();
        end
        msg_valid = 1'b0;
        run(20);

        // reset in the middle of a message
        score_bcd = 16'h0042; score_blank_lz = 1'b1;
        send_msg({7'h08, 7'h08, 7'h08, 7'h08}, 1'b0);
        run(5);
        check("pre_rst_active", msg_active, 1'b1);
        #2 reset = 1'b1;
        #1 check_blank_reset("midrst");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        model_reset();
        run(20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
